// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic multiplier / sequential divider datapaths:
// default widths, divider FSM state encoding and a counter-width helper.
package vedic_pkg;

  localparam int DIVIDEND_W_DEF = 32;
  localparam int DIVISOR_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_divider_32by16_div_step.sv
// Single restoring-division iteration: shift one dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module div_step
  import vedic_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W-1:0] i_rem,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W-1:0] o_rem,
  output logic                 o_q
);

  logic [DIVISOR_W:0] w_partial;
  logic [DIVISOR_W:0] w_diff;

  // One extra bit of headroom, so the compare and subtract can never overflow
  assign w_partial = {i_rem, i_bit};
  assign w_diff    = w_partial - {1'b0, i_divisor};
  assign o_q       = (w_partial >= {1'b0, i_divisor});
  assign o_rem     = o_q ? w_diff[DIVISOR_W-1:0] : w_partial[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_divider_32by16.sv
// Iterative restoring divider with valid/ready handshakes, one quotient bit per
// clock. Optional `SEQ_DIV_ERR_EN short-circuits a zero divisor and flags div_err.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// CALC  | one quotient bit retired per cycle, DIVIDEND_W cycles
// DONE  | out_valid=1, result held until out_ready
module seq_divider_32by16
  import vedic_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_err
);

  localparam int CW = clog2(DIVIDEND_W);

  div_state_t             r_state;
  div_state_t             w_state_nxt;
  logic [DIVIDEND_W-1:0]  r_dvd;
  logic [DIVISOR_W-1:0]   r_dvs;
  logic [DIVISOR_W-1:0]   r_rem;
  logic [CW-1:0]          r_cnt;
  logic [DIVISOR_W-1:0]   w_rem_nxt;
  logic                   w_q_bit;
  logic                   w_last;

  assign w_last = (r_cnt == CW'(DIVIDEND_W - 1));

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[DIVIDEND_W-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_nxt),
    .o_q       (w_q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
`ifdef SEQ_DIV_ERR_EN
          if (divisor == '0) w_state_nxt = DONE;
          else               w_state_nxt = CALC;
`else
          w_state_nxt = CALC;
`endif
        end
      end
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Quotient bits shift into the dividend register as its MSBs are consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd <= dividend;
            r_dvs <= divisor;
            r_rem <= '0;
            r_cnt <= '0;
`ifdef SEQ_DIV_ERR_EN
            if (divisor == '0) begin
              r_dvd <= '1;
              r_rem <= dividend[DIVISOR_W-1:0];
            end
`endif
          end
        end
        CALC: begin
          r_dvd <= {r_dvd[DIVIDEND_W-2:0], w_q_bit};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_DIV_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_err <= 1'b0;
    else if (r_state == IDLE && in_valid) r_err <= (divisor == '0);
  end

  assign div_err = r_err;
`else
  assign div_err = 1'b0;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign quotient  = r_dvd;
  assign remainder = r_rem;

endmodule

// File: tb/tb_seq_divider_32by16.sv
// Self-checking bench for seq_divider_32by16: directed corner cases plus random
// multiply/divide round trips, all checked against plain-arithmetic reference.
module tb_seq_divider_32by16;

  localparam int DW = 32;
  localparam int SW = 16;

`ifdef SEQ_DIV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [SW-1:0] divisor = '0;
  logic          in_ready;
  logic          out_valid;
  logic          div_err;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider_32by16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] a, input logic [SW-1:0] b);
    if (b == 0) return '1;
    return a / DW'(b);
  endfunction

  function automatic logic [SW-1:0] ref_r(input logic [DW-1:0] a, input logic [SW-1:0] b);
    logic [DW-1:0] m;
    if (b == 0) return a[SW-1:0];
    m = a % DW'(b);
    return m[SW-1:0];
  endfunction

  // One transaction; returns what the DUT produced so callers can add checks.
  task automatic run_op(input logic [DW-1:0] a, input logic [SW-1:0] b, input int hold,
                        input string tag, output logic [DW-1:0] q_o, output logic [SW-1:0] r_o);
    int cyc;
    int exp_lat;
    bit zero_err;
    zero_err = ERR_EN && (b == 0);
    exp_lat  = zero_err ? 0 : DW;
    @(negedge clk);
    check({tag, "/in_ready_idle"}, in_ready, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = SW'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, cyc, exp_lat);
    q_o = quotient;
    r_o = remainder;
    check({tag, "/quotient"}, quotient, ref_q(a, b));
    check({tag, "/remainder"}, remainder, ref_r(a, b));
    check({tag, "/div_err"}, div_err, zero_err);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "/hold_q"}, quotient, ref_q(a, b));
      check({tag, "/hold_r"}, remainder, ref_r(a, b));
      check({tag, "/hold_valid"}, out_valid, 1);
      check({tag, "/hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/valid_after_hs"}, out_valid, 0);
    check({tag, "/ready_after_hs"}, in_ready, 1);
  endtask

  initial begin
    logic [DW-1:0] q, a, prod;
    logic [SW-1:0] r, b;
    int seen;
    int got;
    int acc_t[$];
    int hs_t[$];
    logic [DW-1:0] qa[$];
    logic [SW-1:0] qb[$];

    #2 rst_n = 1'b0;
    #20;
    check("rst/in_ready", in_ready, 1);
    check("rst/out_valid", out_valid, 0);
    check("rst/quotient", quotient, 0);
    check("rst/remainder", remainder, 0);
    check("rst/div_err", div_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd100, 16'd7, 0, "d100_7", q, r);
    check("d100_7/q_const", q, 14);
    check("d100_7/r_const", r, 2);

    run_op(32'hFFFE0001, 16'hFFFF, 0, "max_sq", q, r);
    check("max_sq/q_const", q, 32'h0000FFFF);
    check("max_sq/r_const", r, 0);

    run_op(32'h12345678, 16'h0000, 0, "div0", q, r);
    check("div0/q_const", q, 32'hFFFFFFFF);
    check("div0/r_const", r, 16'h5678);

    run_op(32'hFFFFFFFF, 16'h0001, 10, "hold", q, r);

    // Mid-calculation reset must drop the pending result silently
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 16'd7;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort/out_valid", out_valid, 0);
    check("abort/in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort/no_valid_pulse", seen, 0);
    run_op(32'd9, 16'd3, 0, "after_abort", q, r);

    for (int i = 0; i < 1000; i++) begin
      a    = DW'($urandom_range(0, 65535));
      b    = SW'($urandom_range(1, 65535));
      prod = a * DW'(b);
      run_op(prod, b, 0, "roundtrip", q, r);
      check("roundtrip/q_is_a", q, a);
      check("roundtrip/r_zero", r, 0);
    end

    // Back-to-back streaming with in_valid and out_ready both held high
    got = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 600 && got < 5; t++) begin
      if (out_valid) begin
        if (qa.size() > 0) begin
          a = qa.pop_front();
          b = qb.pop_front();
          check("b2b/quotient", quotient, ref_q(a, b));
          check("b2b/remainder", remainder, ref_r(a, b));
        end
        hs_t.push_back(t);
        got++;
        if (got == 5) in_valid = 1'b0;
      end
      if (in_ready && in_valid) begin
        a = $urandom;
        b = SW'($urandom_range(1, 65535));
        dividend = a;
        divisor  = b;
        qa.push_back(a);
        qb.push_back(b);
        acc_t.push_back(t);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b/results", got, 5);
    check("b2b/accepts", acc_t.size(), 5);
    for (int i = 1; i < acc_t.size() && i < hs_t.size() + 1; i++) begin
      check("b2b/period", acc_t[i] - acc_t[i-1], DW + 2);
      check("b2b/accept_after_hs", acc_t[i], hs_t[i-1] + 1);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider_32by16.md
# seq_divider_32by16

Iterative restoring divider: a 32-bit dividend over a 16-bit divisor gives a 32-bit quotient and a 16-bit remainder. It is the inverse of the 16x16 Vedic multiplier datapath. It takes a full 32-bit product and recovers one factor, which also lets the bench round-trip-check multiplier results. Each transfer uses a valid/ready handshake on both the input and output sides. The block retires one quotient bit per clock.

## Interface
- DIVIDEND_W, 32, dividend and quotient width; must be >= DIVISOR_W
- DIVISOR_W, 16, divisor and remainder width
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- dividend  input  DIVIDEND_W  numerator, unsigned
- divisor  input  DIVISOR_W  denominator, unsigned
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- quotient  output  DIVIDEND_W  floor(dividend/divisor)
- remainder  output  DIVISOR_W  dividend mod divisor
- div_err  output  1  divisor was zero (DIV_ERR_EN only; else constant 0)

## Operation
- The FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, the block latches dividend into the shift register and divisor into its register.
  - It clears the partial remainder and the iteration counter, then goes to CALC.
- CALC:
  - in_ready=0.
  - Each cycle it forms partial = {rem, dividend_msb} (DIVISOR_W+1 bits) and shifts the dividend register left.
  - If partial >= {0,divisor}: rem = partial - divisor and the quotient LSB is 1. Otherwise rem = partial[DIVISOR_W-1:0] and the quotient LSB is 0.
  - The quotient bits shift into the vacated dividend LSBs.
  - The counter runs 0..DIVIDEND_W-1. On the last iteration the block goes to DONE.
- DONE:
  - out_valid=1.
  - quotient, remainder and div_err stay stable until out_valid&&out_ready, then the block returns to IDLE.
  - The next operands cannot be accepted until the cycle after the output handshake.
- Divisor 0 without DIV_ERR_EN: the normal iterations naturally yield quotient all-ones and remainder = dividend[DIVISOR_W-1:0].
- Outputs are registered. quotient and remainder keep their last value after the handshake; they are meaningful only while out_valid=1.
- Unsigned arithmetic throughout. The subtract is DIVISOR_W+1 bits wide, so no overflow is possible.

## Timing
- Reset values (async assert, sync deassert at the input): state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_err=0, counter=0.
- Accept at clock edge N. out_valid rises after edge N+DIVIDEND_W (32 cycles).
- Throughput is one operation per DIVIDEND_W+2 cycles at best: accept edge, 32 CALC edges, one output handshake edge.
- in_valid is ignored outside IDLE. The operand buses are sampled only on the accept edge.
- out_ready low in DONE holds the outputs indefinitely. out_ready outside DONE is ignored.
- rst_n asserted mid-CALC or in DONE aborts the operation. The block returns to IDLE, no out_valid pulse occurs, and the pending result is lost.

## Configuration
- `SEQ_DIV_ERR_EN` defined:
  - In IDLE, an accepted divisor of 0 goes directly to DONE on the accept edge, so out_valid appears after 1 cycle.
  - The result is div_err=1, quotient all-ones, remainder = dividend[DIVISOR_W-1:0].
  - div_err is 0 for every nonzero divisor.
- Undefined: div_err is tied 0. A zero divisor takes the full 32-cycle path and produces the same quotient and remainder values.

## Structure
- Shared package `vedic_pkg`:
  - the FSM state enum (IDLE/CALC/DONE);
  - default width constants DIVIDEND_W_DEF=32 and DIVISOR_W_DEF=16, also reused by the multiplier;
  - the counter width function clog2(DIVIDEND_W).
- One natural sub-module, `div_step`: a combinational single-iteration cell. Inputs are rem, the incoming bit and divisor. Outputs are next rem and the quotient bit. This keeps the FSM/handshake logic separate from the arithmetic.

## Test plan
- dividend=100, divisor=7 -> after 32 cycles out_valid, quotient=14, remainder=2, div_err=0.
- dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0x0000FFFF, remainder=0. Also check multiplier round-trip on 1000 random a*b/b pairs, requiring quotient=a and remainder=0.
- dividend=0x12345678, divisor=0:
  - with SEQ_DIV_ERR_EN -> out_valid after 1 cycle, div_err=1, quotient=0xFFFFFFFF, remainder=0x5678;
  - without it -> out_valid after 32 cycles, the same quotient/remainder, div_err=0.
- dividend=0xFFFFFFFF, divisor=1 with out_ready held low for 10 cycles -> outputs stable at quotient=0xFFFFFFFF, remainder=0 throughout, in_ready=0; the handshake completes on the first out_ready=1 edge.
- Assert rst_n at iteration 15 of 100/7 -> no out_valid, in_ready=1 after reset. A following 9/3 gives quotient=3, remainder=0.
- Back-to-back: in_valid held high with out_ready=1 -> a new accept on the cycle after each output handshake, a 34-cycle period, and no operand skipped or duplicated.
